// File: rtl/act_arbiter.sv
// Round-robin arbiter and sequencer that time-shares one combinational
// sigmoid / inverse-sigmoid unit between NREQ requesters.
module act_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 3
) (
    input  logic                    CLOCK_50,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_func,
    input  logic [32*NREQ-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [31:0]             rsp_data,
    output logic [31:0]             spu_x,
    input  logic [31:0]             spu_y,
    output logic [31:0]             ispu_x,
    input  logic [31:0]             ispu_y,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   pick;
    logic [31:0]     op_q;
    logic            func_q;
    logic            accept;
    logic            eval_done;
    logic [NREQ-1:0] hi_mask;
    logic [NREQ-1:0] masked;
    logic [NREQ-1:0] pick_vec;

    // Round-robin: prefer requesters above last_grant, else wrap to the lowest set bit.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            hi_mask[i] = (i > int'(last_grant));
        end
        masked   = req_valid & hi_mask;
        pick_vec = (masked != '0) ? masked : req_valid;
        pick     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pick_vec[i]) pick = IW'(i);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Handshake: a request is taken in the IDLE cycle where req_valid[i] and
    // req_ready[i] are both high; req_ready is only ever raised in IDLE.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        eval_done = 1'b0;
        spu_x     = 32'h0;
        ispu_x    = 32'h0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (req_valid != '0) begin
                    req_ready[pick] = 1'b1;
                    accept          = 1'b1;
                    state_nxt       = EVAL;
                end
            end
            EVAL: begin
                // Only the selected unit sees the operand; the other input stays quiet.
                if (func_q) ispu_x = op_q;
                else        spu_x  = op_q;
                if (cnt == '0) begin
                    eval_done = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            last_grant <= IW'(NREQ - 1);
            grant_id   <= '0;
            op_q       <= 32'h0;
            func_q     <= 1'b0;
            rsp_data   <= 32'h0;
            rsp_valid  <= '0;
        end else begin
            rsp_valid <= '0;
            if (accept) begin
                op_q       <= req_data[32*pick +: 32];
                func_q     <= req_func[pick];
                last_grant <= pick;
                grant_id   <= pick;
                cnt        <= CW'(LAT - 1);
            end else if (state == EVAL && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (eval_done) begin
                rsp_data            <= func_q ? ispu_y : spu_y;
                rsp_valid[grant_id] <= 1'b1;
            end
        end
    end

endmodule

// File: doc/act_arbiter.md
# act_arbiter

Shared-activation-unit arbiter and sequencer for the neural SoC datapath. Up to NREQ requesters (the software PIO bridge and the hardware neuron engines) submit one 32-bit IEEE-754 single-precision operand each, and select sigmoid or inverse sigmoid. The block grants one requester at a time, round-robin, and drives the operand into the single shared combinational spu or ispu. It allows a fixed multicycle settling window, registers the result, and returns it to the granted requester with a one-cycle response pulse. It replaces the ad-hoc HALT/RUN software handshake around the activation units.

## Interface
- NREQ, 4, number of requesters; 2..8
- LAT, 3, settling cycles allowed for the combinational spu/ispu path; ≥1
- CLOCK_50  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  request pending, one bit per requester
- req_func  in  NREQ  per requester: 0 = sigmoid, 1 = inverse sigmoid
- req_data  in  32*NREQ  operand; requester i at [32i+31:32i]
- req_ready  out  NREQ  one-hot accept strobe
- rsp_valid  out  NREQ  one-hot, registered, one-cycle result strobe
- rsp_data  out  32  result of the last completed operation; shared by all requesters
- spu_x  out  32  operand to the sigmoid unit
- spu_y  in  32  sigmoid result
- ispu_x  out  32  operand to the inverse-sigmoid unit
- ispu_y  in  32  inverse-sigmoid result
- busy  out  1  high in EVAL and DONE
- grant_id  out  $clog2(NREQ)  index of the current or last granted requester

## Operation
- The FSM has three states: IDLE, EVAL and DONE.
- **IDLE**
  - If any req_valid bit is set, the grant g is the first set bit searched from (last_grant+1) mod NREQ upward, with wrap.
  - req_ready[g]=1 combinationally in this cycle; all other req_ready bits stay 0.
  - On the clock edge: capture operand and func into registers, set last_grant and grant_id to g, load cnt to LAT-1, and go to EVAL.
  - If no req_valid bit is set, remain in IDLE and keep req_ready all 0.
- **EVAL**
  - The operand register drives spu_x when func=0, or ispu_x when func=1. The unselected input is held at 32'h0 (operand isolation).
  - If cnt≠0, decrement cnt.
  - If cnt=0, capture rsp_data from spu_y or ispu_y according to func, and go to DONE.
- **DONE**
  - rsp_valid[g]=1 for exactly one cycle (registered).
  - Return to IDLE. No request is accepted during DONE.
- req_valid, req_func and req_data are sampled only in IDLE. req_ready is 0 in EVAL and DONE.
- A requester holds its data and func stable while req_valid=1 and until it sees req_ready.
  - It may withdraw a request (drop req_valid) before it is granted. A withdrawn request is never granted.
- Requester inputs are ignored outside IDLE, so changes there cannot corrupt the in-flight operation.
- rsp_data holds its value until the next capture.
- No arithmetic is performed in this block. Results pass through bit-exact; NaN and Inf are not treated specially.

## Timing
- Reset (asynchronous, effective immediately) sets:
  - state=IDLE, cnt=0
  - last_grant=NREQ-1, so the first grant goes to requester 0
  - grant_id=0, operand register=0, func=0
  - rsp_data=0, rsp_valid=0, busy=0
  - spu_x=0, ispu_x=0, req_ready=0
- Accept in cycle T. EVAL occupies cycles T+1 … T+LAT. rsp_valid is asserted in cycle T+LAT+1.
- The earliest next req_ready is cycle T+LAT+2, giving a maximum throughput of one operation per LAT+2 cycles.
- The spu/ispu path is constrained as a multicycle path of LAT cycles from the operand register to rsp_data.
- Reset mid-EVAL or mid-DONE aborts the operation: no rsp_valid is produced, and round-robin restarts at requester 0.
- When req_valid toggles in the same cycle as the IDLE decision, the value present in that cycle governs the grant.

## Test plan
- Single sigmoid request, LAT=3:
  - Stimulus: req_valid[0]=1, req_func[0]=0, req_data[0]=32'h00000000, with the model spu returning 32'h3F000000.
  - Required response: req_ready=4'b0001 at T, spu_x=0 during T+1..T+3, ispu_x=0, rsp_valid=4'b0001 at T+4, rsp_data=32'h3F000000.
- Inverse request:
  - Stimulus: requester 2, req_func=1, req_data=32'h3F000000, with the model ispu returning 32'h00000000.
  - Required response: ispu_x=32'h3F000000 during EVAL, spu_x=0, rsp_valid=4'b0100, rsp_data=0, grant_id=2.
- Round-robin fairness:
  - Stimulus: all four req_valid bits held high.
  - Required response: grants 0,1,2,3,0, each spaced LAT+2=5 cycles apart, with grant_id tracking.
- Withdrawal:
  - Stimulus: requesters 1 and 3 valid while requester 0 is in EVAL; requester 1 drops req_valid before the next IDLE.
  - Required response: the next grant is 3, and requester 1 never sees req_ready.
- Reset mid-EVAL:
  - Stimulus: assert reset_n=0 at T+2.
  - Required response: all outputs go to their reset values immediately, and no rsp_valid is produced. After release with req_valid=4'b1010, the grant is 1.
- Input stability:
  - Stimulus: change req_data[0] during EVAL.
  - Required response: spu_x and rsp_data still reflect the originally accepted operand.
